// File: rtl/prog_loader.sv
// Byte-stream program loader: parses SYNC/LEN/payload/CSUM frames, writes the
// payload into instruction memory and releases the processor once the checksum matches.
module prog_loader #(
    parameter logic [7:0] SYNC      = 8'hA5,
    parameter int         MEM_DEPTH = 4096,
    parameter int         ADDR_W    = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              proc_run,
    output logic              err_len,
    output logic              err_csum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t              r_state;
    logic [7:0]          r_len_hi;
    logic [15:0]         r_len;
    logic [15:0]         r_cnt;
    logic [7:0]          r_sum;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [7:0]          r_mem_wdata;
    logic                r_busy;
    logic                r_proc_run;
    logic                r_err_len;
    logic                r_err_csum;

    logic [15:0]         w_len;
    logic [31:0]         w_len_ext;
    logic                w_len_bad;
    logic [15:0]         w_cnt_inc;
    logic                w_is_sync;

    assign w_len     = {r_len_hi, in_byte};
    assign w_len_ext = {16'd0, w_len};
    assign w_len_bad = (w_len == 16'd0) || (w_len_ext > 32'(MEM_DEPTH));
    assign w_cnt_inc = r_cnt + 16'd1;
    assign w_is_sync = (in_byte == SYNC);

    // The loader never stalls the source: every offered byte is consumed.
    assign in_ready  = 1'b1;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;
    assign proc_run  = r_proc_run;
    assign err_len   = r_err_len;
    assign err_csum  = r_err_csum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_len_hi    <= 8'd0;
            r_len       <= 16'd0;
            r_cnt       <= 16'd0;
            r_sum       <= 8'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'd0;
            r_busy      <= 1'b0;
            r_proc_run  <= 1'b0;
            r_err_len   <= 1'b0;
            r_err_csum  <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            if (in_valid) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_is_sync) begin
                            r_state <= S_LEN_HI;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_LEN_HI: begin
                        r_len_hi <= in_byte;
                        r_state  <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        if (w_len_bad) begin
                            r_state   <= S_ERR;
                            r_err_len <= 1'b1;
                            r_busy    <= 1'b0;
                        end else begin
                            r_len   <= w_len;
                            r_cnt   <= 16'd0;
                            r_sum   <= 8'd0;
                            r_state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_cnt[ADDR_W-1:0];
                        r_mem_wdata <= in_byte;
                        r_cnt       <= w_cnt_inc;
                        r_sum       <= r_sum + in_byte;
                        // Counter is 16 bits wide so LEN == MEM_DEPTH terminates before any wrap.
                        if (w_cnt_inc == r_len) begin
                            r_state <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        r_busy <= 1'b0;
                        if (in_byte == r_sum) begin
                            r_state    <= S_DONE;
                            r_proc_run <= 1'b1;
                        end else begin
                            r_state    <= S_ERR;
                            r_err_csum <= 1'b1;
                        end
                    end
                    S_DONE, S_ERR: begin
                        if (w_is_sync) begin
                            r_state    <= S_LEN_HI;
                            r_busy     <= 1'b1;
                            r_proc_run <= 1'b0;
                            r_err_len  <= 1'b0;
                            r_err_csum <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames plus randomized frames,
// checked against a frame-level model of the loader.
module tb_prog_loader;

    localparam logic [7:0] SYNC_C = 8'hA5;
    localparam int         DEPTH  = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'd0;
    logic        in_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        proc_run;
    logic        err_len;
    logic        err_csum;

    int total = 0;
    int bad   = 0;

    logic [7:0] fq[$];

    prog_loader #(.SYNC(SYNC_C), .MEM_DEPTH(DEPTH), .ADDR_W(12)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .proc_run(proc_run),
        .err_len(err_len), .err_csum(err_csum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Offer one byte after an optional idle gap, then sample just after the transfer edge.
    task automatic xfer(input logic [7:0] b, input int gap, input logic ew,
                        input logic [31:0] ea, input logic [7:0] ed, input logic eb);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        @(posedge clk);
        #1;
        chk("mem_we", mem_we, ew);
        if (ew) begin
            chk("mem_addr", mem_addr, ea);
            chk("mem_wdata", mem_wdata, ed);
        end
        chk("busy", busy, eb);
    endtask

    // Expected behaviour is derived from the frame layout: locate SYNC, decode LEN,
    // payload byte j lands at address j, checksum is the payload sum mod 256.
    task automatic send_frame(input logic [7:0] q[$], input bit gaps);
        int s;
        int len;
        int sum;
        int gap;
        bit lerr;
        s = -1;
        for (int k = 0; k < q.size(); k++)
            if (s < 0 && q[k] == SYNC_C) s = k;
        len  = int'(q[s+1]) * 256 + int'(q[s+2]);
        lerr = (len == 0) || (len > DEPTH);
        sum  = 0;
        if (!lerr)
            for (int k = s + 3; k < s + 3 + len; k++) sum += int'(q[k]);
        for (int k = 0; k < q.size(); k++) begin
            gap = 0;
            if (gaps && $urandom_range(0, 3) == 0) gap = int'($urandom_range(1, 3));
            if (k < s) begin
                xfer(q[k], gap, 1'b0, 0, 8'd0, 1'b0);
            end else if (k == s) begin
                xfer(q[k], gap, 1'b0, 0, 8'd0, 1'b1);
                chk("proc_run_at_sync", proc_run, 0);
                chk("err_len_at_sync", err_len, 0);
                chk("err_csum_at_sync", err_csum, 0);
            end else if (k == s + 1) begin
                xfer(q[k], gap, 1'b0, 0, 8'd0, 1'b1);
            end else if (k == s + 2) begin
                xfer(q[k], gap, 1'b0, 0, 8'd0, !lerr);
                chk("err_len", err_len, 32'(lerr));
            end else if (k < s + 3 + len) begin
                xfer(q[k], gap, 1'b1, k - s - 3, q[k], 1'b1);
            end else begin
                xfer(q[k], gap, 1'b0, 0, 8'd0, 1'b0);
                chk("proc_run", proc_run, 32'(q[k] == sum[7:0]));
                chk("err_csum", err_csum, 32'(q[k] != sum[7:0]));
                chk("err_len_final", err_len, 0);
            end
        end
        if (lerr) chk("proc_run_lenerr", proc_run, 0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_mem_we", mem_we, 0);
        $display("frame: len=%0d sum=%02h proc_run=%0b err_len=%0b err_csum=%0b",
                 len, sum[7:0], proc_run, err_len, err_csum);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_proc_run"}, proc_run, 0);
        chk({tag, "_err_len"}, err_len, 0);
        chk({tag, "_err_csum"}, err_csum, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int len;
        int sum;
        logic [7:0] b;

        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("in_ready", in_ready, 1);

        fq = {SYNC_C, 8'h00, 8'h03, 8'h30, 8'hF4, 8'h00, 8'h24};
        send_frame(fq, 1'b0);

        fq = {SYNC_C, 8'h00, 8'h02, 8'h10, 8'h20, 8'h31};
        send_frame(fq, 1'b0);
        fq = {SYNC_C, 8'h00, 8'h01, 8'hFF, 8'hFF};
        send_frame(fq, 1'b0);

        fq = {SYNC_C, 8'h00, 8'h00};
        send_frame(fq, 1'b0);
        fq = {SYNC_C, 8'h10, 8'h01};
        send_frame(fq, 1'b0);

        fq = {8'h00, 8'h13, SYNC_C, 8'h00, 8'h01, SYNC_C, SYNC_C};
        send_frame(fq, 1'b1);

        // Abort a LEN=5 frame after its second payload byte.
        xfer(SYNC_C, 0, 1'b0, 0, 8'd0, 1'b1);
        xfer(8'h00, 0, 1'b0, 0, 8'd0, 1'b1);
        xfer(8'h05, 0, 1'b0, 0, 8'd0, 1'b1);
        xfer(8'h11, 0, 1'b1, 0, 8'h11, 1'b1);
        xfer(8'h22, 0, 1'b1, 1, 8'h22, 1'b1);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        in_valid = 1'b1;
        in_byte  = 8'h33;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("midrst_mem_we", mem_we, 0);
            chk("midrst_busy", busy, 0);
        end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        $display("reset pulse applied mid-frame");
        fq = {SYNC_C, 8'h00, 8'h01, 8'h7F, 8'h7F};
        send_frame(fq, 1'b0);

        fq = {SYNC_C, 8'h10, 8'h00};
        for (int i = 0; i < DEPTH; i++) fq.push_back(8'(i));
        fq.push_back(8'h00);
        send_frame(fq, 1'b0);

        for (int f = 0; f < 8; f++) begin
            fq = {};
            for (int j = int'($urandom_range(0, 2)); j > 0; j--) begin
                b = 8'($urandom_range(0, 255));
                if (b == SYNC_C) b = 8'h00;
                fq.push_back(b);
            end
            len = int'($urandom_range(1, 24));
            fq.push_back(SYNC_C);
            fq.push_back(8'h00);
            fq.push_back(8'(len));
            sum = 0;
            for (int j = 0; j < len; j++) begin
                b = 8'($urandom_range(0, 255));
                sum += int'(b);
                fq.push_back(b);
            end
            if ($urandom_range(0, 2) == 0) fq.push_back(8'(sum + 1));
            else fq.push_back(8'(sum));
            send_frame(fq, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
